// File: rtl/pim_seq_ctrl.sv
// PIM access sequencer: setup/pulse/hold strobe timing for read, program and erase.
// Define PIM_PROG_VERIFY_EN to add a read-back verify phase after every program.
module pim_seq_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [CNT_W-1:0]  cfg_setup,
    input  logic [CNT_W-1:0]  cfg_pulse_rd,
    input  logic [CNT_W-1:0]  cfg_pulse_pg,
    input  logic [CNT_W-1:0]  cfg_pulse_er,
    input  logic [CNT_W-1:0]  cfg_hold,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] pim_addr,
    output logic [DATA_W-1:0] pim_wd,
    input  logic [DATA_W-1:0] pim_rd,
    output logic              pim_rd_en,
    output logic              pim_pg_en,
    output logic              pim_er_en,
    output logic              busy
);

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_PG = 2'b01;
    localparam logic [1:0] OP_ER = 2'b10;

`ifdef PIM_PROG_VERIFY_EN
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RESP, VSETUP, VPULSE, VHOLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RESP} state_t;
`endif

    state_t            state_q, state_d, pulse_exit_state, hold_exit_state;
    logic [CNT_W-1:0]  cnt_q, cnt_d, pulse_exit_cnt, hold_exit_cnt;
    logic [CNT_W-1:0]  setup_q, setup_d, pulse_q, pulse_d, hold_q, hold_d;
    logic [CNT_W-1:0]  pulse_rd_q, pulse_rd_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d, rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rd_en_q, rd_en_d, pg_en_q, pg_en_d, er_en_q, er_en_d;
    logic              last;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign last = (cnt_q == CNT_W'(1));

    // Where PULSE and HOLD lead to; shared by both exits so HOLD can be skipped cleanly.
    always_comb begin
        hold_exit_state = RESP;
        hold_exit_cnt   = cnt_q;
`ifdef PIM_PROG_VERIFY_EN
        if (op_q == OP_PG) begin
            if (setup_q != '0) begin
                hold_exit_state = VSETUP;
                hold_exit_cnt   = setup_q;
            end else begin
                hold_exit_state = VPULSE;
                hold_exit_cnt   = pulse_rd_q;
            end
        end
`endif
        if (hold_q != '0) begin
            pulse_exit_state = HOLD;
            pulse_exit_cnt   = hold_q;
        end else begin
            pulse_exit_state = hold_exit_state;
            pulse_exit_cnt   = hold_exit_cnt;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        setup_d    = setup_q;
        pulse_d    = pulse_q;
        hold_d     = hold_q;
        pulse_rd_d = pulse_rd_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    setup_d    = cfg_setup;
                    hold_d     = cfg_hold;
                    pulse_rd_d = at_least_one(cfg_pulse_rd);
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    case (req_op)
                        OP_RD:   pulse_d = at_least_one(cfg_pulse_rd);
                        OP_PG:   pulse_d = at_least_one(cfg_pulse_pg);
                        OP_ER:   pulse_d = at_least_one(cfg_pulse_er);
                        default: pulse_d = CNT_W'(1);
                    endcase
                    // Illegal ops idle one cycle in HOLD (strobes low, pins untouched) before RESP.
                    if (req_op == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        addr_d = req_addr;
                        wd_d   = req_wdata;
                        if (cfg_setup != '0) begin
                            state_d = SETUP;
                            cnt_d   = cfg_setup;
                        end else begin
                            state_d = PULSE;
                            cnt_d   = pulse_d;
                        end
                    end
                end
            end
            SETUP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = PULSE;
                    cnt_d   = pulse_q;
                end
            end
            PULSE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    if (op_q == OP_RD) rdata_d = pim_rd;
                    state_d = pulse_exit_state;
                    cnt_d   = pulse_exit_cnt;
                end
            end
            HOLD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = hold_exit_state;
                    cnt_d   = hold_exit_cnt;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
`ifdef PIM_PROG_VERIFY_EN
            VSETUP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    state_d = VPULSE;
                    cnt_d   = pulse_rd_q;
                end
            end
            VPULSE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    rdata_d = pim_rd;
                    err_d   = (pim_rd != wd_q);
                    if (hold_q != '0) begin
                        state_d = VHOLD;
                        cnt_d   = hold_q;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            VHOLD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) state_d = RESP;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they are registered and mutually exclusive.
        rd_en_d = (state_d == PULSE) && (op_d == OP_RD);
`ifdef PIM_PROG_VERIFY_EN
        rd_en_d = rd_en_d || (state_d == VPULSE);
`endif
        pg_en_d = (state_d == PULSE) && (op_d == OP_PG);
        er_en_d = (state_d == PULSE) && (op_d == OP_ER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            setup_q    <= '0;
            pulse_q    <= '0;
            hold_q     <= '0;
            pulse_rd_q <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            pg_en_q    <= 1'b0;
            er_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            setup_q    <= setup_d;
            pulse_q    <= pulse_d;
            hold_q     <= hold_d;
            pulse_rd_q <= pulse_rd_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            rd_en_q    <= rd_en_d;
            pg_en_q    <= pg_en_d;
            er_en_q    <= er_en_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign pim_addr  = addr_q;
    assign pim_wd    = wd_q;
    assign pim_rd_en = rd_en_q;
    assign pim_pg_en = pg_en_q;
    assign pim_er_en = er_en_q;

endmodule
